// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard.
// Shadow entry layout and default pipeline depth.
package issue_scoreboard_pkg;
  typedef logic [4:0] reg_addr_t;
  typedef logic [3:0] iq_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } sb_entry_t;

  localparam int PIPE_DEPTH_DEFAULT = 3;
endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-queue head bundle between queue and scoreboard.
// master = issue queue, slave = scoreboard.
interface issue_scoreboard_if #(
  parameter int IQ_AW = 4
);
  import issue_scoreboard_pkg::*;

  logic [IQ_AW-1:0]  iq_size;
  reg_addr_t [1:0]   head_rs;
  logic [1:0]        head_rs_use;
  reg_addr_t [1:0]   head_rt;
  logic [1:0]        head_rt_use;
  reg_addr_t [1:0]   head_rd;
  logic [1:0]        head_rd_we;
  logic [1:0]        iq_pop_number;
  logic [1:0]        issue_valid;

  modport master (
    output iq_size, head_rs, head_rs_use,
    output head_rt, head_rt_use,
    output head_rd, head_rd_we,
    input  iq_pop_number, issue_valid
  );

  modport slave (
    input  iq_size, head_rs, head_rs_use,
    input  head_rt, head_rt_use,
    input  head_rd, head_rd_we,
    output iq_pop_number, issue_valid
  );
endinterface

// File: rtl/issue_scoreboard_hazard_check.sv
// RAW check of one slot's two sources against the shadow array.
// Entries flagged in byp_i are ignored (regfile bypass).
module sb_hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int N = 6
) (
  input  sb_entry_t [N-1:0] sh_i,
  input  logic [N-1:0]      byp_i,
  input  reg_addr_t         rs_i,
  input  logic              rs_use_i,
  input  reg_addr_t         rt_i,
  input  logic              rt_use_i,
  output logic              haz_o
);
  logic rs_live;
  logic rt_live;

  assign rs_live = rs_use_i && (rs_i != '0);
  assign rt_live = rt_use_i && (rt_i != '0);

  // any live source matching a live, non-bypassed writer
  always_comb begin
    haz_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sh_i[i].valid && !byp_i[i]) begin
        if (rs_live && (rs_i == sh_i[i].rd))
          haz_o = 1'b1;
        if (rt_live && (rt_i == sh_i[i].rd))
          haz_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue hazard controller with an in-flight writer shadow.
// Optional ISSUE_SB_PERF_EN adds issue/hazard counters.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int IQ_AW      = 4,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int WB_BYPASS  = 0
) (
  input  logic                clk,
  input  logic                rst,
  issue_scoreboard_if.slave   iq,
  input  logic                stall_in,
  input  logic                flush_in,
`ifdef ISSUE_SB_PERF_EN
  output logic [31:0]         perf_hazard_cycles,
  output logic [31:0]         perf_dual_issue,
  output logic [31:0]         perf_single_issue,
`endif
  output logic [31:0]         busy_mask
);
  localparam int N = 2 * PIPE_DEPTH;

  sb_entry_t [N-1:0] sh_q, sh_d;
  logic [31:0]       busy_d;
  logic [N-1:0]      byp;
  logic              v0, v1, h0, h1;
  logic              raw, waw, g0, g1;

  assign v0 = iq.iq_size >= IQ_AW'(1);
  assign v1 = iq.iq_size >= IQ_AW'(2);

  // last stage writes the regfile this cycle; skip it when bypassed
  always_comb begin
    byp = '0;
    if (WB_BYPASS != 0)
      byp[N-1 -: 2] = 2'b11;
  end

  sb_hazard_check #(.N(N)) u_hz0 (
    .sh_i     (sh_q),
    .byp_i    (byp),
    .rs_i     (iq.head_rs[0]),
    .rs_use_i (iq.head_rs_use[0]),
    .rt_i     (iq.head_rt[0]),
    .rt_use_i (iq.head_rt_use[0]),
    .haz_o    (h0)
  );

  sb_hazard_check #(.N(N)) u_hz1 (
    .sh_i     (sh_q),
    .byp_i    (byp),
    .rs_i     (iq.head_rs[1]),
    .rs_use_i (iq.head_rs_use[1]),
    .rt_i     (iq.head_rt[1]),
    .rt_use_i (iq.head_rt_use[1]),
    .haz_o    (h1)
  );

  // intra-pair dependencies and in-order grants
  always_comb begin
    raw = iq.head_rd_we[0] && (iq.head_rd[0] != '0) &&
          ((iq.head_rs_use[1] && (iq.head_rs[1] == iq.head_rd[0])) ||
           (iq.head_rt_use[1] && (iq.head_rt[1] == iq.head_rd[0])));
    waw = iq.head_rd_we[0] && iq.head_rd_we[1] &&
          (iq.head_rd[0] != '0) &&
          (iq.head_rd[0] == iq.head_rd[1]);
    g0  = v0 && !stall_in && !flush_in && !h0;
    g1  = g0 && v1 && !h1 && !raw && !waw;
  end

  assign iq.issue_valid   = {g1, g0};
  assign iq.iq_pop_number = {1'b0, g0} + {1'b0, g1};

  // shadow next state: flush clears, stall holds, else shift in
  always_comb begin
    sh_d = sh_q;
    if (flush_in) begin
      sh_d = '0;
    end else if (!stall_in) begin
      for (int i = N - 1; i >= 2; i--)
        sh_d[i] = sh_q[i-2];
      sh_d[0].valid = g0 && iq.head_rd_we[0] &&
                      (iq.head_rd[0] != '0);
      sh_d[0].rd    = iq.head_rd[0];
      sh_d[1].valid = g1 && iq.head_rd_we[1] &&
                      (iq.head_rd[1] != '0);
      sh_d[1].rd    = iq.head_rd[1];
    end
  end

  // decode pending writers into the busy mask
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < N; i++)
      if (sh_d[i].valid)
        busy_d[sh_d[i].rd] = 1'b1;
  end

  // shadow and busy mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q      <= '0;
      busy_mask <= '0;
    end else begin
      sh_q      <= sh_d;
      busy_mask <= busy_d;
    end
  end

`ifdef ISSUE_SB_PERF_EN
  // wrapping issue and hazard counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hazard_cycles <= '0;
      perf_dual_issue    <= '0;
      perf_single_issue  <= '0;
    end else begin
      if (v0 && !g0 && !stall_in)
        perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
      if (g1)
        perf_dual_issue <= perf_dual_issue + 32'd1;
      if (g0 && !g1)
        perf_single_issue <= perf_single_issue + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard.
// Runs a no-bypass and a bypass instance side by side.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_in = 1'b0;
  logic flush_in = 1'b0;
  logic [31:0] busy0, busy1;
  int n_assert = 0;
  int n_fail = 0;

  issue_scoreboard_if #(.IQ_AW(4)) iq0 ();
  issue_scoreboard_if #(.IQ_AW(4)) iq1 ();

`ifdef ISSUE_SB_PERF_EN
  logic [31:0] ph0, pd0, ps0, ph1, pd1, ps1;
`endif

  always #5 clk = ~clk;

  issue_scoreboard #(.IQ_AW(4), .PIPE_DEPTH(3), .WB_BYPASS(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .iq        (iq0),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
`ifdef ISSUE_SB_PERF_EN
    .perf_hazard_cycles (ph0),
    .perf_dual_issue    (pd0),
    .perf_single_issue  (ps0),
`endif
    .busy_mask (busy0)
  );

  issue_scoreboard #(.IQ_AW(4), .PIPE_DEPTH(3), .WB_BYPASS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .iq        (iq1),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
`ifdef ISSUE_SB_PERF_EN
    .perf_hazard_cycles (ph1),
    .perf_dual_issue    (pd1),
    .perf_single_issue  (ps1),
`endif
    .busy_mask (busy1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // size, rs0, rs1, rs_use, rt0, rt1, rt_use, rd0, rd1, rd_we
  task automatic drv(input logic [3:0] sz,
                     input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [1:0] rsu,
                     input logic [4:0] rt0, input logic [4:0] rt1,
                     input logic [1:0] rtu,
                     input logic [4:0] rd0, input logic [4:0] rd1,
                     input logic [1:0] we);
    iq0.iq_size = sz;          iq1.iq_size = sz;
    iq0.head_rs = {rs1, rs0};  iq1.head_rs = {rs1, rs0};
    iq0.head_rs_use = rsu;     iq1.head_rs_use = rsu;
    iq0.head_rt = {rt1, rt0};  iq1.head_rt = {rt1, rt0};
    iq0.head_rt_use = rtu;     iq1.head_rt_use = rtu;
    iq0.head_rd = {rd1, rd0};  iq1.head_rd = {rd1, rd0};
    iq0.head_rd_we = we;       iq1.head_rd_we = we;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall_in = 1'b0;
    flush_in = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_pop", 32'(iq0.iq_pop_number), 0);
    chk("rst_iv", 32'(iq0.issue_valid), 0);
    chk("rst_busy", busy0, 0);

    // independent pair issues together
    drv(2, 3, 4, 2'b11, 0, 0, 0, 1, 2, 2'b11);
    chk("t1_pop", 32'(iq0.iq_pop_number), 2);
    chk("t1_iv", 32'(iq0.issue_valid), 3);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy", busy0, 32'h6);

    // reset mid-flight drops tracking
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", busy0, 0);

    // intra-pair RAW, then dependent latency
    do_reset();
    drv(2, 0, 5, 2'b10, 0, 0, 0, 5, 9, 2'b01);
    chk("t2_pop0", 32'(iq0.iq_pop_number), 1);
    chk("t2_pop0_byp", 32'(iq1.iq_pop_number), 1);
    cyc();
    drv(1, 5, 0, 2'b01, 0, 0, 0, 9, 0, 2'b00);
    chk("t2_busy1", busy0, 32'h20);
    chk("t2_pop1", 32'(iq0.iq_pop_number), 0);
    chk("t2_pop1_byp", 32'(iq1.iq_pop_number), 0);
    cyc();
    chk("t2_pop2", 32'(iq0.iq_pop_number), 0);
    chk("t2_pop2_byp", 32'(iq1.iq_pop_number), 0);
    cyc();
    chk("t2_pop3", 32'(iq0.iq_pop_number), 0);
    chk("t2_pop3_byp", 32'(iq1.iq_pop_number), 1);
    cyc();
    chk("t2_pop4", 32'(iq0.iq_pop_number), 1);
    chk("t2_busy4", busy0, 0);

    // intra-pair RAW through rt
    do_reset();
    drv(2, 0, 0, 2'b00, 0, 6, 2'b10, 6, 8, 2'b11);
    chk("rt_raw_pop", 32'(iq0.iq_pop_number), 1);
    // unused rs does not cause a hazard
    drv(2, 0, 6, 2'b00, 0, 0, 0, 6, 8, 2'b11);
    chk("nouse_pop", 32'(iq0.iq_pop_number), 2);

    // r0 never hazards nor gets tracked
    do_reset();
    drv(2, 0, 0, 2'b10, 0, 0, 2'b10, 0, 0, 2'b01);
    chk("t3_pop", 32'(iq0.iq_pop_number), 2);
    cyc();
    chk("t3_busy", busy0, 0);

    // WAW in pair blocks slot 1 only
    do_reset();
    drv(2, 1, 2, 2'b11, 0, 0, 0, 7, 7, 2'b11);
    chk("t4_pop", 32'(iq0.iq_pop_number), 1);
    chk("t4_iv", 32'(iq0.issue_valid), 1);
    cyc();
    drv(1, 2, 0, 2'b01, 0, 0, 0, 7, 0, 2'b01);
    chk("t4_busy", busy0, 32'h80);
    chk("t4_pop_next", 32'(iq0.iq_pop_number), 1);

    // stall freezes, flush with stall clears
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 3, 0, 2'b01);
    chk("t5_pop_w", 32'(iq0.iq_pop_number), 1);
    cyc();
    drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    stall_in = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_pop", 32'(iq0.iq_pop_number), 0);
      chk("t5_stall_busy", busy0, 32'h8);
      cyc();
    end
    chk("t5_stall_busy_end", busy0, 32'h8);
    flush_in = 1'b1;
    #1;
    chk("t5_flush_pop", 32'(iq0.iq_pop_number), 0);
    cyc();
    flush_in = 1'b0;
    stall_in = 1'b0;
    #1;
    chk("t5_flush_busy", busy0, 0);
    chk("t5_dep_pop", 32'(iq0.iq_pop_number), 1);

    // occupancy limits
    do_reset();
    drv(1, 1, 2, 2'b11, 0, 0, 0, 3, 4, 2'b11);
    chk("t6_sz1_pop", 32'(iq0.iq_pop_number), 1);
    chk("t6_sz1_iv", 32'(iq0.issue_valid), 1);
    drv(0, 1, 2, 2'b11, 0, 0, 0, 3, 4, 2'b11);
    chk("t6_sz0_pop", 32'(iq0.iq_pop_number), 0);
    chk("t6_sz0_iv", 32'(iq0.issue_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue-stage hazard controller for the dual-issue in-order pipeline. Each cycle it decides how many of the two issue-queue head entries (0, 1 or 2) may issue, and drives the issue queue's pop count. It tracks register writers in flight through the EX/MEM/CMT register stages in a shadow pipeline that shifts in step with the datapath. It enforces RAW hazards against in-flight writers, plus intra-pair RAW and WAW rules, and honours pipeline stall and flush.

Parameters:
IQ_AW, 4, width of the issue-queue occupancy count (iq_size).
PIPE_DEPTH, 3, number of register stages between issue and regfile write (is_to_ex, ex_to_mem, mem_to_cmt).
WB_BYPASS, 0, 1 = regfile forwards a same-cycle write to a same-cycle read, so writers in the last stage are not hazards.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous, active-high reset.
iq_size  in  IQ_AW  current issue-queue occupancy.
head_rs  in  2x5  source register A of head slots 0/1.
head_rs_use  in  2  slot reads rs.
head_rt  in  2x5  source register B of head slots 0/1.
head_rt_use  in  2  slot reads rt.
head_rd  in  2x5  destination register of head slots 0/1.
head_rd_we  in  2  slot writes rd.
stall_in  in  1  downstream stall; freezes issue and the shadow pipeline.
flush_in  in  1  squash of all in-flight instructions.
iq_pop_number  out  2  number of entries issued this cycle (0..2).
issue_valid  out  2  per-slot issue grant; always 00, 01 or 11.
busy_mask  out  32  registers with a pending in-flight writer.

Behaviour:
Slot validity:
- Slot 0 valid iff iq_size >= 1.
- Slot 1 valid iff iq_size >= 2.

Shadow pipeline:
- PIPE_DEPTH stages x 2 slots; each entry holds {valid, rd}.
- Stage 1 is loaded at the clock edge after issue.
- Stage k shifts to stage k+1 each edge; stage PIPE_DEPTH is the entry writing the regfile that cycle.
- Only issued slots with rd_we=1 and rd!=0 are recorded valid.

Hazard rules:
- A source (use bit set, address != 0) is hazardous if it matches any valid shadow entry.
- When WB_BYPASS=1, stage-PIPE_DEPTH entries are excluded from the hazard check.
- Register 0 never causes a hazard.

Grants (combinational, same cycle):
- g0 = slot0 valid & !stall_in & !flush_in & no hazard on slot 0.
- g1 = g0 & slot1 valid & no hazard on slot 1 & no intra-pair RAW & no intra-pair WAW.
- Intra-pair RAW: slot 1 reads slot 0's rd while slot 0 has rd_we and rd != 0.
- Intra-pair WAW: both slots write the same nonzero rd.
- Slot 1 never issues without slot 0 (in-order).
- iq_pop_number = g0 + g1; issue_valid = {g1, g0}.

Stall and flush:
- Stall: shadow pipeline holds all contents; grants are 0.
- Flush: all shadow entries are cleared at the edge; grants are 0 that cycle.
- Flush together with stall: flush wins and the shadow pipeline is cleared.

Outputs:
- busy_mask is registered: the OR of decoded valid shadow rd values, updated each edge.

Reset:
- Shadow pipeline cleared; busy_mask = 0.
- Grants depend only on inputs, so after reset they are 0 whenever iq_size = 0.
- Reset asserted mid-operation discards all in-flight tracking at that edge.

Issue latency for a dependent instruction:
- Writer issued in cycle t: the dependent issues at t+PIPE_DEPTH+1 when WB_BYPASS=0, or at t+PIPE_DEPTH when WB_BYPASS=1, assuming no stalls.

Optional Feature:
ISSUE_SB_PERF_EN
- With the macro, the block adds three 32-bit wrapping counters, cleared on reset:
  - perf_hazard_cycles counts cycles with slot0 valid, g0=0 and stall_in=0.
  - perf_dual_issue counts cycles with iq_pop_number=2.
  - perf_single_issue counts cycles with iq_pop_number=1.
- The three counters are exposed as output ports.
- Without the macro, these ports and counters do not exist and there is no logic overhead.

Decomposition:
Shared package (defines.svh):
- Shadow-entry struct SB_ENTRY {bool valid; REG_ADDR rd}.
- Use the existing REG_ADDR and IQ_ADDR types.
- Constant PIPE_DEPTH_DEFAULT = 3.

Sub-module:
- sb_hazard_check: one combinational compare of a slot's two sources against the shadow array and a bypass mask.
- Instantiated twice, once per slot.

Test Plan:
1. After reset, iq_size=2, slot0 rd=1 rs=3, slot1 rd=2 rs=4, all writes enabled -> iq_pop_number=2, busy_mask bits 1,2 set next cycle.
2. Slot0 rd=5, slot1 rs=5, WB_BYPASS=0 -> pop=1 at t. Next head reads r5 -> pop=0 at t+1..t+3, pop>=1 at t+4. With WB_BYPASS=1 -> issues at t+3.
3. Slot0 writes rd=0, slot1 reads r0 -> pop=2 and busy_mask stays 0.
4. Both slots rd=7, independent sources -> pop=1. Next cycle, second head is not blocked by WAW alone -> pop>=1.
5. Writer in stage 1, stall_in=1 for 3 cycles -> pop=0 and busy_mask unchanged throughout. Then flush_in=1 with stall_in=1 -> busy_mask=0 next cycle; a dependent issues immediately.
6. iq_size=1 with independent heads -> pop=1. iq_size=0 -> pop=0, issue_valid=00.
